// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel edge engine.
// Builds the 3x3 neighbourhood from a raster pixel stream with two line
// buffers, then computes a gradient magnitude (L1 or scaled L2) and an edge flag.
// Border centres are forced to zero. Pipeline: window -> gradient -> output regs.
//
// Handshake: a pixel moves on an edge where in_valid && in_ready, and a result
// moves on an edge where out_valid && out_ready. A stall
// (out_valid && !out_ready) freezes every stage, and in_ready is low whenever
// the pipeline is stalled or the frame is being flushed.
// Outputs hold steady while stalled.
module sobel_stream #(
  parameter int PIX_W    = 8,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int MODE     = 0,
  parameter int SQ_SHIFT = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic [PIX_W-1:0] thresh,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_edge,
  output logic             out_border,
  output logic             out_last,
  output logic [1:0]       fsm_state
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int GW = PIX_W + 4;
  localparam int MW = 2 * GW;
  localparam logic [XW-1:0]    X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0]    Y_LAST  = YW'(IMG_H - 1);
  localparam logic [YW-1:0]    Y_ONE   = YW'(1);
  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t state, state_n;

  logic clear, stall, accept, issue, last_issued;
  logic [XW-1:0] ix, ox;
  logic [YW-1:0] iy, oy;

  // Line buffers: lb_top holds row y-2 and lb_mid holds row y-1, indexed by column.
  logic [PIX_W-1:0] lb_top [IMG_W];
  logic [PIX_W-1:0] lb_mid [IMG_W];

  // 3x3 window: rows t/m/b, columns l/c/r.
  logic [PIX_W-1:0] tl, tc, tr, ml, mc, mr, bl, bc, br;

  logic             v1, border1, last1;
  logic [PIX_W-1:0] thr1;
  logic             v2, border2, last2;
  logic [PIX_W-1:0] thr2;
  logic signed [GW-1:0] gx_c, gy_c, gx2, gy2;
  logic [GW-1:0]    ax, ay;
  logic [MW-1:0]    mag;
  logic [PIX_W-1:0] sat;

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  assign clear     = rst || start;
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall && (state != FLUSH);
  assign accept    = in_valid && in_ready;
  // In FLUSH the engine issues its own (border) results until the frame's last centre has gone in.
  assign issue     = ((state == RUN) && accept) || ((state == FLUSH) && !stall && !last_issued);
  assign fsm_state = state;

  // State register; rst and start both force a fresh frame.
  always_ff @(posedge clock) begin
    if (clear) state <= FILL;
    else       state <= state_n;
  end

  // Next-state logic: FILL until the pixel that completes the first window, RUN to the frame's last pixel, then FLUSH.
  always_comb begin
    state_n = state;
    case (state)
      FILL:    if (accept && (ix == '0) && (iy == Y_ONE)) state_n = RUN;
      RUN:     if (accept && (ix == X_LAST) && (iy == Y_LAST)) state_n = FLUSH;
      FLUSH:   if (out_valid && out_ready && out_last) state_n = FILL;
      default: state_n = FILL;
    endcase
  end

  // Input raster position and output centre position, both wrapping per frame.
  always_ff @(posedge clock) begin
    if (clear) begin
      ix          <= '0;
      iy          <= '0;
      ox          <= '0;
      oy          <= '0;
      last_issued <= 1'b0;
    end else begin
      if (accept) begin
        if (ix == X_LAST) begin
          ix <= '0;
          iy <= (iy == Y_LAST) ? '0 : iy + YW'(1);
        end else begin
          ix <= ix + XW'(1);
        end
      end
      if (issue) begin
        last_issued <= (ox == X_LAST) && (oy == Y_LAST);
        if (ox == X_LAST) begin
          ox <= '0;
          oy <= (oy == Y_LAST) ? '0 : oy + YW'(1);
        end else begin
          ox <= ox + XW'(1);
        end
      end
    end
  end

  // Line buffer update and window shift on every accepted pixel; contents are never cleared.
  always_ff @(posedge clock) begin
    if (accept) begin
      lb_top[ix] <= lb_mid[ix];
      lb_mid[ix] <= in_pixel;
      tl <= tc;  tc <= tr;  tr <= lb_top[ix];
      ml <= mc;  mc <= mr;  mr <= lb_mid[ix];
      bl <= bc;  bc <= br;  br <= in_pixel;
    end
  end

  // Stage 1 side-band: validity, border/last classification of the centre, and its threshold.
  always_ff @(posedge clock) begin
    if (clear) begin
      v1      <= 1'b0;
      border1 <= 1'b0;
      last1   <= 1'b0;
      thr1    <= '0;
    end else if (!stall) begin
      v1      <= issue;
      border1 <= (ox == '0) || (ox == X_LAST) || (oy == '0) || (oy == Y_LAST);
      last1   <= (ox == X_LAST) && (oy == Y_LAST);
      thr1    <= thresh;
    end
  end

  assign gx_c = (ext(tr) + (ext(mr) <<< 1) + ext(br)) - (ext(tl) + (ext(ml) <<< 1) + ext(bl));
  assign gy_c = (ext(bl) + (ext(bc) <<< 1) + ext(br)) - (ext(tl) + (ext(tc) <<< 1) + ext(tr));

  // Stage 2: register the signed gradients.
  always_ff @(posedge clock) begin
    if (clear) begin
      v2      <= 1'b0;
      border2 <= 1'b0;
      last2   <= 1'b0;
      thr2    <= '0;
      gx2     <= '0;
      gy2     <= '0;
    end else if (!stall) begin
      v2      <= v1;
      border2 <= border1;
      last2   <= last1;
      thr2    <= thr1;
      gx2     <= gx_c;
      gy2     <= gy_c;
    end
  end

  // Magnitude and saturation; MW holds the worst-case sum of squares.
  always_comb begin
    ax  = gx2[GW-1] ? unsigned'(-gx2) : unsigned'(gx2);
    ay  = gy2[GW-1] ? unsigned'(-gy2) : unsigned'(gy2);
    mag = '0;
    if (MODE == 0) mag = MW'(ax) + MW'(ay);
    else           mag = ((MW'(ax) * MW'(ax)) + (MW'(ay) * MW'(ay))) >> SQ_SHIFT;
    sat = (mag > MW'(PIX_MAX)) ? PIX_MAX : mag[PIX_W-1:0];
  end

  // Stage 3: output registers; borders are forced to zero with no edge.
  always_ff @(posedge clock) begin
    if (clear) begin
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      out_edge   <= 1'b0;
      out_border <= 1'b0;
      out_last   <= 1'b0;
    end else if (!stall) begin
      out_valid  <= v2;
      out_pixel  <= (v2 && !border2) ? sat : '0;
      out_edge   <= v2 && !border2 && (sat >= thr2);
      out_border <= v2 && border2;
      out_last   <= v2 && last2;
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: bench for sobel_stream on an 8x6 frame.
// Two instances share one stream: one computes the L1 magnitude and one the scaled L2 magnitude.
module tb_sobel_stream;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic       clock;
  logic       rst, start;
  logic [7:0] thresh, in_pixel;
  logic       in_valid, out_ready;

  logic       in_ready0, out_valid0, out_edge0, out_border0, out_last0;
  logic [7:0] out_pixel0;
  logic [1:0] fsm_state0;
  logic       in_ready1, out_valid1, out_edge1, out_border1, out_last1;
  logic [7:0] out_pixel1;
  logic [1:0] fsm_state1;

  sobel_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H), .MODE(0), .SQ_SHIFT(8)) dut0 (
    .clock(clock), .rst(rst), .start(start), .thresh(thresh),
    .in_valid(in_valid), .in_ready(in_ready0), .in_pixel(in_pixel),
    .out_valid(out_valid0), .out_ready(out_ready), .out_pixel(out_pixel0),
    .out_edge(out_edge0), .out_border(out_border0), .out_last(out_last0),
    .fsm_state(fsm_state0)
  );

  sobel_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H), .MODE(1), .SQ_SHIFT(8)) dut1 (
    .clock(clock), .rst(rst), .start(start), .thresh(thresh),
    .in_valid(in_valid), .in_ready(in_ready1), .in_pixel(in_pixel),
    .out_valid(out_valid1), .out_ready(out_ready), .out_pixel(out_pixel1),
    .out_edge(out_edge1), .out_border(out_border1), .out_last(out_last1),
    .fsm_state(fsm_state1)
  );

  // Clock and reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int kind;   // 0 flat 100, 1 vertical step, 2 ramp 10*x, 3 random, 4 random low-contrast
    int thr;    // -1 picks a random threshold
    int rdy;    // 0 always ready, 1 toggling, 2 random
    int gaps;   // 1 inserts random input bubbles
    int e0;     // expected L1 edge count, -1 unchecked
    int e1;     // expected L2 edge count, -1 unchecked
  } vec_t;

  vec_t tbl [9];

  int   img [N];
  int   thr_frame;
  int   ptr, feed_lim, rdy_mode, gaps;
  bit   tog;
  int   cyc, acc_cyc, first_out_cyc;
  int   nout, nb, ne0, ne1, nlast;
  int   n_tests, n_fail;
  logic [19:0] exp_q[$];   // {last, border, edge1, pix1, edge0, pix0}

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int px(input int x, input int y);
    return img[y * W + x];
  endfunction

  // Reference model: Sobel at centre k straight from the definition.
  function automatic logic [19:0] model(input int k);
    int x, y, gx, gy, m0, m1;
    logic [7:0] p0, p1;
    logic lst, e0, e1;
    x   = k % W;
    y   = k / W;
    lst = (k == N - 1);
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1)
      return {lst, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0};
    gx = (px(x+1, y-1) + 2 * px(x+1, y) + px(x+1, y+1)) - (px(x-1, y-1) + 2 * px(x-1, y) + px(x-1, y+1));
    gy = (px(x-1, y+1) + 2 * px(x, y+1) + px(x+1, y+1)) - (px(x-1, y-1) + 2 * px(x, y-1) + px(x+1, y-1));
    m0 = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    m1 = (gx * gx + gy * gy) / 256;
    p0 = (m0 > 255) ? 8'd255 : 8'(m0);
    p1 = (m1 > 255) ? 8'd255 : 8'(m1);
    e0 = (int'(p0) >= thr_frame);
    e1 = (int'(p1) >= thr_frame);
    return {lst, 1'b0, e1, p1, e0, p0};
  endfunction

  // Driver: present the next pixel (or a bubble) and the out_ready pattern.
  task automatic drive();
    in_valid = (ptr < feed_lim) && (gaps == 0 || $urandom_range(0, 3) != 0);
    in_pixel = (ptr < N) ? 8'(img[ptr]) : 8'd0;
    thresh   = 8'(thr_frame);
    tog      = ~tog;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = tog;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // One clock: monitor and scoreboard at the falling edge, then advance and re-drive.
  task automatic step();
    logic acc;
    logic [19:0] e;
    @(negedge clock);
    if (out_valid0 && !out_ready) chk("in_ready_stalled", int'(in_ready0), 0);
    if (out_valid0 && first_out_cyc < 0) first_out_cyc = cyc;
    acc = in_valid && in_ready0;
    if (acc && ptr == W + 1) acc_cyc = cyc;
    if (out_valid0 && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("pix0[%0d]", nout), int'(out_pixel0), int'(e[7:0]));
        chk($sformatf("edge0[%0d]", nout), int'(out_edge0), int'(e[8]));
        chk($sformatf("valid1[%0d]", nout), int'(out_valid1), 1);
        chk($sformatf("pix1[%0d]", nout), int'(out_pixel1), int'(e[16:9]));
        chk($sformatf("edge1[%0d]", nout), int'(out_edge1), int'(e[17]));
        chk($sformatf("border[%0d]", nout), int'(out_border0), int'(e[18]));
        chk($sformatf("last[%0d]", nout), int'(out_last0), int'(e[19]));
        nout++;
        nb    += int'(out_border0);
        ne0   += int'(out_edge0);
        ne1   += int'(out_edge1);
        nlast += int'(out_last0);
      end
    end
    @(posedge clock);
    cyc++;
    if (acc) ptr++;
    #1 drive();
  endtask

  task automatic load_frame(input int kind, input int thr);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       img[i] = 100;
        1:       img[i] = ((i % W) < 4) ? 0 : 255;
        2:       img[i] = 10 * (i % W);
        3:       img[i] = $urandom_range(0, 255);
        default: img[i] = $urandom_range(0, 40);
      endcase
    end
    thr_frame = (thr < 0) ? $urandom_range(0, 255) : thr;
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back(model(k));
    ptr = 0;  feed_lim = N;
    nout = 0; nb = 0; ne0 = 0; ne1 = 0; nlast = 0;
    first_out_cyc = -1;
    acc_cyc = -1;
  endtask

  task automatic run_frame(input int kind, input int thr, input int rdy, input int gp, input int e0, input int e1);
    load_frame(kind, thr);
    rdy_mode = rdy;
    gaps     = gp;
    for (int b = 0; b < 4000 && (ptr < N || exp_q.size() != 0); b++) step();
    chk("frame_done", int'(ptr == N && exp_q.size() == 0), 1);
    chk("latency", first_out_cyc - acc_cyc, 3);
    chk("outputs", nout, N);
    chk("borders", nb, 2 * W + 2 * H - 4);
    chk("lasts", nlast, 1);
    chk("state_idle", int'(fsm_state0), 0);
    if (e0 >= 0) chk("edges0", ne0, e0);
    if (e1 >= 0) chk("edges1", ne1, e1);
  endtask

  initial begin
    int seen;
    n_tests = 0; n_fail = 0; cyc = 0; tog = 1'b0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = 8'd0; thresh = 8'd0; out_ready = 1'b1;
    ptr = 0; feed_lim = 0; rdy_mode = 0; gaps = 0; thr_frame = 0;

    tbl[0] = '{0,   1, 0, 0,  0, 0};
    tbl[1] = '{1, 128, 0, 0,  8, 8};
    tbl[2] = '{2,  50, 0, 0, 24, 0};
    tbl[3] = '{0,   1, 1, 0,  0, 0};
    tbl[4] = '{1, 128, 1, 0,  8, 8};
    tbl[5] = '{2,  50, 1, 0, 24, 0};
    tbl[6] = '{3,  -1, 2, 1, -1, -1};
    tbl[7] = '{4,  -1, 2, 1, -1, -1};
    tbl[8] = '{4,  -1, 0, 1, -1, -1};

    repeat (3) @(posedge clock);
    #1 rst = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", int'(out_valid0), 0);
    chk("rst_in_ready", int'(in_ready0), 1);
    chk("rst_out_pixel", int'(out_pixel0), 0);
    chk("rst_out_edge", int'(out_edge0), 0);
    chk("rst_out_border", int'(out_border0), 0);
    chk("rst_out_last", int'(out_last0), 0);
    chk("rst_state", int'(fsm_state0), 0);

    for (int t = 0; t < 9; t++)
      run_frame(tbl[t].kind, tbl[t].thr, tbl[t].rdy, tbl[t].gaps, tbl[t].e0, tbl[t].e1);

    // rst after 20 accepted pixels, then a complete new frame
    load_frame(3, -1);
    feed_lim = 20; rdy_mode = 0; gaps = 0;
    for (int b = 0; b < 200 && ptr < 20; b++) step();
    chk("rst_fed", ptr, 20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clock);
    chk("midrst_out_valid", int'(out_valid0), 0);
    chk("midrst_in_ready", int'(in_ready0), 1);
    chk("midrst_state", int'(fsm_state0), 0);
    run_frame(3, -1, 0, 0, -1, -1);

    // start pulse while flushing
    load_frame(2, 50);
    rdy_mode = 0; gaps = 0;
    for (int b = 0; b < 400 && ptr < N; b++) step();
    step();
    step();
    chk("in_flush", int'(fsm_state0), 2);
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clock);
    chk("start_out_valid", int'(out_valid0), 0);
    chk("start_in_ready", int'(in_ready0), 1);
    chk("start_state", int'(fsm_state0), 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      seen += int'(out_valid0) + int'(out_last0);
    end
    chk("start_no_output", seen, 0);
    run_frame(4, -1, 2, 1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
